// File: rtl/operand_mem_pn.sv
// Parametrised operand memory: one write port and two registered, valid-qualified read ports.
// Reads of entries never written since reset still return data but flag rerr.
module operand_mem_pn #(
    parameter int          DATA_W    = 16,
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1111_0000,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              wen,
    input  logic [31:0]       waddr,
    input  logic [31:0]       wdata,
    input  logic              ren1,
    input  logic [31:0]       raddr1,
    input  logic              ren2,
    input  logic [31:0]       raddr2,
    output logic [DATA_W-1:0] mem_read_data1,
    output logic [DATA_W-1:0] mem_read_data2,
    output logic              rvalid1,
    output logic              rvalid2,
    output logic              rerr1,
    output logic              rerr2,
    output logic              werr,
    output logic              pair_ready,
    output logic [DEPTH-1:0]  written
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    // An address hits only when word-aligned and its word offset lies inside the window.
    function automatic logic dec_hit(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr[1:0] == 2'b00) && (off[1:0] == 2'b00) &&
               ({2'b00, off[31:2]} < DEPTH_U);
    endfunction

    function automatic logic [IDX_W-1:0] dec_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_written;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic              r_rvalid1;
    logic              r_rvalid2;
    logic              r_rerr1;
    logic              r_rerr2;
    logic              r_werr;
    logic              r_pair_ready;

    logic              w_whit;
    logic [IDX_W-1:0]  w_widx;
    logic              w_wr_hit;
    logic              w_hit1;
    logic [IDX_W-1:0]  w_idx1;
    logic              w_hit2;
    logic [IDX_W-1:0]  w_idx2;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic              w_rerr1;
    logic              w_rerr2;
    logic              w_unused_wdata;

    assign w_wdata        = wdata[DATA_W-1:0];
    assign w_unused_wdata = ^(wdata >> DATA_W);

    // Address decode for the write port and both read ports.
    always_comb begin
        w_whit   = dec_hit(waddr);
        w_widx   = dec_idx(waddr);
        w_wr_hit = wen & w_whit;
        w_hit1   = dec_hit(raddr1);
        w_idx1   = dec_idx(raddr1);
        w_hit2   = dec_hit(raddr2);
        w_idx2   = dec_idx(raddr2);
    end

    // Port-1 read resolution, including same-cycle forwarding of the write data.
    always_comb begin
        w_rdata1 = '0;
        w_rerr1  = 1'b1;
        if (w_hit1) begin
            if (BYPASS && w_wr_hit && (w_widx == w_idx1)) begin
                w_rdata1 = w_wdata;
                w_rerr1  = 1'b0;
            end else begin
                w_rdata1 = r_mem[w_idx1];
                w_rerr1  = ~r_written[w_idx1];
            end
        end else begin
            w_rdata1 = '0;
            w_rerr1  = 1'b1;
        end
    end

    // Port-2 read resolution, mirroring port 1.
    always_comb begin
        w_rdata2 = '0;
        w_rerr2  = 1'b1;
        if (w_hit2) begin
            if (BYPASS && w_wr_hit && (w_widx == w_idx2)) begin
                w_rdata2 = w_wdata;
                w_rerr2  = 1'b0;
            end else begin
                w_rdata2 = r_mem[w_idx2];
                w_rerr2  = ~r_written[w_idx2];
            end
        end else begin
            w_rdata2 = '0;
            w_rerr2  = 1'b1;
        end
    end

    // Storage array and written-since-reset flags.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_written <= '0;
        end else if (w_wr_hit) begin
            r_mem[w_widx]     <= w_wdata;
            r_written[w_widx] <= 1'b1;
        end else begin
            r_written <= r_written;
        end
    end

    // Registered responses; data holds between reads, rerr is cleared when not valid.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rdata1     <= '0;
            r_rdata2     <= '0;
            r_rvalid1    <= 1'b0;
            r_rvalid2    <= 1'b0;
            r_rerr1      <= 1'b0;
            r_rerr2      <= 1'b0;
            r_werr       <= 1'b0;
            r_pair_ready <= 1'b0;
        end else begin
            r_rvalid1    <= ren1;
            r_rvalid2    <= ren2;
            r_rerr1      <= ren1 & w_rerr1;
            r_rerr2      <= ren2 & w_rerr2;
            r_werr       <= wen & ~w_whit;
            r_pair_ready <= ren1 & ren2 & ~w_rerr1 & ~w_rerr2;
            if (ren1) begin
                r_rdata1 <= w_rdata1;
            end else begin
                r_rdata1 <= r_rdata1;
            end
            if (ren2) begin
                r_rdata2 <= w_rdata2;
            end else begin
                r_rdata2 <= r_rdata2;
            end
        end
    end

    assign mem_read_data1 = r_rdata1;
    assign mem_read_data2 = r_rdata2;
    assign rvalid1        = r_rvalid1;
    assign rvalid2        = r_rvalid2;
    assign rerr1          = r_rerr1;
    assign rerr2          = r_rerr2;
    assign werr           = r_werr;
    assign pair_ready     = r_pair_ready;
    assign written        = r_written;

endmodule

// File: doc/operand_mem_pn.md
Name: operand_mem_pn

Overview:
- Parametrised successor to the fixed six-entry operand memory that feeds the arithmetic datapath.
- Holds DEPTH operand words of DATA_W bits at a byte-addressed window, on a 32-bit bus clocked by PCLK.
- Provides one write port and two independent read ports with registered, valid-qualified responses, per-entry written flags, decode-error reporting and optional write-to-read forwarding.

Parameters:
- DATA_W, 16, operand word width; write data is truncated to the low DATA_W bits.
- DEPTH, 8, number of entries (2..256).
- BASE_ADDR, 32'h1111_0000, byte address of entry 0; word stride 4.
- BYPASS, 1, 1 = a read of an entry written in the same cycle returns the new data; 0 = it returns the old data.

Ports:
- PCLK  in  1  clock; all state updates on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- wen  in  1  write strobe.
- waddr  in  32  write byte address.
- wdata  in  32  write data; bits [DATA_W-1:0] are stored.
- ren1  in  1  port-1 read strobe.
- raddr1  in  32  port-1 read byte address.
- ren2  in  1  port-2 read strobe.
- raddr2  in  32  port-2 read byte address.
- mem_read_data1  out  DATA_W  port-1 read data.
- mem_read_data2  out  DATA_W  port-2 read data.
- rvalid1  out  1  port-1 response valid, one-cycle pulse.
- rvalid2  out  1  port-2 response valid, one-cycle pulse.
- rerr1  out  1  port-1 decode error or unwritten entry; qualified by rvalid1.
- rerr2  out  1  port-2 decode error or unwritten entry; qualified by rvalid2.
- werr  out  1  write decode error, one-cycle pulse.
- pair_ready  out  1  pulse when both ports return error-free data in the same cycle.
- written  out  DEPTH  per-entry written-since-reset flags.

Behaviour:
- Decode: an address hits entry i when addr == BASE_ADDR + 4*i and 0 <= i < DEPTH. Misaligned addresses (addr[1:0] != 0) and addresses outside the window are decode errors.
- Reset, sampled on a PCLK edge with PRESET=1:
  - all entries cleared to 0 and written cleared to 0;
  - mem_read_data1/2 = 0;
  - rvalid1/2, rerr1/2, werr and pair_ready = 0;
  - any in-flight read response is discarded.
  - Reset overrides wen/ren in the same cycle.
- Write:
  - wen=1 with a hit stores wdata[DATA_W-1:0] into entry i and sets written[i]. written is visible one cycle after the edge.
  - wen=1 with a decode error changes no state; werr=1 on the next cycle for exactly one cycle.
  - wen=0: no effect.
- Read latency is 1 cycle. renN=1 at edge k gives rvalidN=1 during cycle k+1 with mem_read_dataN and rerrN valid.
  - Hit on an entry with written[i]=1: data = entry contents, rerrN=0.
  - Hit on an entry with written[i]=0: data = entry contents (0 after reset), rerrN=1.
  - Decode error: data = 0, rerrN=1.
- Hold: mem_read_dataN holds its last value while rvalidN=0. rvalidN deasserts the cycle after the last renN. Back-to-back reads give one response per cycle.
- Same-cycle write and read to the same entry:
  - BYPASS=1: the read returns the new wdata with rerr=0, treating written as already set.
  - BYPASS=0: the read returns the prior contents and the prior written state.
- Both read ports may address the same entry simultaneously; both return identical data.
- pair_ready = rvalid1 & rvalid2 & ~rerr1 & ~rerr2, registered alongside the responses (same cycle as rvalid).
- Reset asserted mid-stream: the cycle after the reset edge has all outputs at reset values, even when ren was high during reset.

Test Plan:
- Reset, then read entry 0 (raddr1=32'h1111_0000) -> cycle+1: rvalid1=1, mem_read_data1=0, rerr1=1; written=0.
- Write 32'hABCD_1234 to 32'h1111_0004, next cycle read it on port 2 -> mem_read_data2=16'h1234, rerr2=0, written[1]=1.
- Write entries 2 and 3 with 16'h0011 and 16'h0111, then read both ports together -> both rvalid=1, data 16'h0011/16'h0111, pair_ready=1 for one cycle.
- Write to 32'h1111_0002 and to 32'h1111_0020 (DEPTH=8) -> werr pulses once for each, written unchanged. Read 32'h1111_0020 -> rerr1=1, data 0.
- Same-cycle write 16'h5A5A and read of entry 4 -> BYPASS=1 returns 16'h5A5A with rerr=0; BYPASS=0 build returns 0 with rerr=1.
- Continuous reads, then PRESET for one cycle with ren1=ren2=1 -> following cycle rvalid=0, data=0; all previously written entries read back 0 with rerr=1.
